// File: rtl/addsub_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// addsub_arbiter_pkg
// Shared definitions for the arbitrated saturating add/sub unit: the operand
// width, the two saturation limits, the controller state encoding and a small
// helper for round-robin index arithmetic.
// Ports: none (package).
// -----------------------------------------------------------------------------
package addsub_arbiter_pkg;

   // Width of every operand and result handled by the shared datapath.
   localparam int OPW = 16;

   // Clamp values used when a signed result leaves the 16-bit range.
   localparam logic [OPW-1:0] SAT_POS = 16'h7FFF;
   localparam logic [OPW-1:0] SAT_NEG = 16'h8000;

   // Controller states: waiting for a request, computing, presenting a result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Index that lies 'off' positions after 'base' on a ring of 'n' requesters.
   function automatic int wrapIdx(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/addsub_arbiter_sat_addsub16.sv
// -----------------------------------------------------------------------------
// sat_addsub16
// Purely combinational 16-bit signed add/subtract with saturation.
// Subtraction is done as A + ~B + 1 so one adder serves both operations.
// Ports:
//   a, b  : signed operands
//   sub   : 1 = a - b, 0 = a + b
//   sum   : result, clamped to 0x7FFF / 0x8000 on signed overflow
//   ovfl  : high when the result had to be clamped
// -----------------------------------------------------------------------------
module sat_addsub16
   import addsub_arbiter_pkg::*;
(
   input  logic [OPW-1:0] a,
   input  logic [OPW-1:0] b,
   input  logic           sub,
   output logic [OPW-1:0] sum,
   output logic           ovfl
);

   logic [OPW-1:0] w_bEff;
   logic [OPW-1:0] w_raw;

   // The effective B operand is inverted for subtraction; the carry-in of one
   // completes the two's complement negation.
   assign w_bEff = sub ? ~b : b;
   assign w_raw  = a + w_bEff + {{(OPW-1){1'b0}}, sub};

   // Overflow is only possible when both effective operands share a sign; it
   // shows up as a raw sign that disagrees with that shared sign.
   assign ovfl = (a[OPW-1] == w_bEff[OPW-1]) && (w_raw[OPW-1] != a[OPW-1]);

   // A raw sign of 1 after overflow means two positives wrapped negative, so
   // clamp high; a raw sign of 0 means two negatives wrapped positive.
   assign sum = ovfl ? (w_raw[OPW-1] ? SAT_POS : SAT_NEG) : w_raw;

endmodule

// File: rtl/addsub_arbiter.sv
// -----------------------------------------------------------------------------
// addsub_arbiter
// Shares one saturating 16-bit add/sub datapath between NREQ requesters.
// A round-robin arbiter picks one request per operation, the operands are
// registered, the result is computed in one cycle and then held on a single
// response channel until the consumer accepts it. A saturating counter tracks
// how many operations overflowed.
// Ports:
//   clk, rst_n    : clock (rising edge) and asynchronous active-low reset
//   req_valid     : per-requester request valid
//   req_a, req_b  : packed operands, 16-bit slice i belongs to requester i
//   req_sub       : per-requester operation select, 1 = A-B
//   req_ready     : one-hot accept strobe back to the granted requester
//   rsp_valid     : result valid, held until rsp_ready
//   rsp_ready     : consumer accepts the result
//   rsp_id        : index of the requester owning the result
//   rsp_sum       : saturated result
//   rsp_ovfl      : result was saturated
//   ovfl_cnt      : number of overflowed operations, sticks at 0xFFFF
//   ovfl_cnt_clr  : synchronous clear of ovfl_cnt, wins over an increment
// -----------------------------------------------------------------------------
module addsub_arbiter
   import addsub_arbiter_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [16*NREQ-1:0]  req_a,
   input  logic [16*NREQ-1:0]  req_b,
   input  logic [NREQ-1:0]     req_sub,
   output logic [NREQ-1:0]     req_ready,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [15:0]         rsp_sum,
   output logic                rsp_ovfl,
   output logic [15:0]         ovfl_cnt,
   input  logic                ovfl_cnt_clr
);

   state_t          r_state;
   state_t          w_nextState;

   logic [IDW-1:0]  r_lastGrant;
   logic            w_anyValid;
   logic [IDW-1:0]  w_grantIdx;
   logic [NREQ-1:0] w_grantOneHot;
   logic [OPW-1:0]  w_selA;
   logic [OPW-1:0]  w_selB;
   logic            w_selSub;

   logic [OPW-1:0]  r_opA;
   logic [OPW-1:0]  r_opB;
   logic            r_opSub;
   logic [IDW-1:0]  r_opId;

   logic [OPW-1:0]  w_sum;
   logic            w_ovfl;

   logic            r_rspValid;
   logic [IDW-1:0]  r_rspId;
   logic [OPW-1:0]  r_rspSum;
   logic            r_rspOvfl;
   logic [15:0]     r_ovflCnt;

   logic            w_accept;

   // Round-robin search: start one past the last granted requester and take
   // the first valid one, wrapping around the ring. The winner's operands are
   // muxed out here so the accept edge can register them directly.
   always_comb begin
      w_anyValid    = 1'b0;
      w_grantIdx    = '0;
      w_grantOneHot = '0;
      w_selA        = '0;
      w_selB        = '0;
      w_selSub      = 1'b0;
      for (int off = 1; off <= NREQ; off++) begin
         if (!w_anyValid && req_valid[wrapIdx(int'(r_lastGrant), off, NREQ)]) begin
            w_anyValid = 1'b1;
            w_grantIdx = IDW'(wrapIdx(int'(r_lastGrant), off, NREQ));
            w_grantOneHot[wrapIdx(int'(r_lastGrant), off, NREQ)] = 1'b1;
            w_selA   = req_a[wrapIdx(int'(r_lastGrant), off, NREQ)*OPW +: OPW];
            w_selB   = req_b[wrapIdx(int'(r_lastGrant), off, NREQ)*OPW +: OPW];
            w_selSub = req_sub[wrapIdx(int'(r_lastGrant), off, NREQ)];
         end
      end
   end

   // Controller state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and accept strobe. Grant and accept coincide in IDLE; EXEC is
   // always a single cycle; HOLD waits for the consumer. There is no path
   // from HOLD straight to a new accept, so issues are at least 3 cycles apart.
   always_comb begin
      w_nextState = r_state;
      req_ready   = '0;
      case (r_state)
         IDLE: begin
            if (w_anyValid) begin
               req_ready   = w_grantOneHot;
               w_nextState = EXEC;
            end
         end
         EXEC: begin
            w_nextState = HOLD;
         end
         HOLD: begin
            if (rsp_ready) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   assign w_accept = (r_state == IDLE) && w_anyValid;

   // Capture the granted request and remember who won, so the next search
   // starts after it. Reset points at the last requester, giving requester 0
   // first priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opA       <= '0;
         r_opB       <= '0;
         r_opSub     <= 1'b0;
         r_opId      <= '0;
         r_lastGrant <= IDW'(NREQ - 1);
      end else if (w_accept) begin
         r_opA       <= w_selA;
         r_opB       <= w_selB;
         r_opSub     <= w_selSub;
         r_opId      <= w_grantIdx;
         r_lastGrant <= w_grantIdx;
      end
   end

   // Shared saturating datapath fed only from the captured operands, so
   // requester activity after the accept cannot disturb the result.
   sat_addsub16 u_satAddSub (
      .a    (r_opA),
      .b    (r_opB),
      .sub  (r_opSub),
      .sum  (w_sum),
      .ovfl (w_ovfl)
   );

   // Response channel: loaded at the end of EXEC, then frozen until the
   // consumer takes it in HOLD. Only rsp_valid drops on acceptance; the data
   // registers keep their last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rspValid <= 1'b0;
         r_rspId    <= '0;
         r_rspSum   <= '0;
         r_rspOvfl  <= 1'b0;
      end else if (r_state == EXEC) begin
         r_rspValid <= 1'b1;
         r_rspId    <= r_opId;
         r_rspSum   <= w_sum;
         r_rspOvfl  <= w_ovfl;
      end else if ((r_state == HOLD) && rsp_ready) begin
         r_rspValid <= 1'b0;
      end
   end

   // Overflow event counter. Clear beats a simultaneous increment, and the
   // count sticks at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovflCnt <= '0;
      end else if (ovfl_cnt_clr) begin
         r_ovflCnt <= '0;
      end else if ((r_state == EXEC) && w_ovfl && (r_ovflCnt != 16'hFFFF)) begin
         r_ovflCnt <= r_ovflCnt + 16'd1;
      end
   end

   assign rsp_valid = r_rspValid;
   assign rsp_id    = r_rspId;
   assign rsp_sum   = r_rspSum;
   assign rsp_ovfl  = r_rspOvfl;
   assign ovfl_cnt  = r_ovflCnt;

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
Shares one 16-bit saturating add/sub datapath between NREQ requesters, e.g. the ALU, the address generator and the branch-target calculator. A round-robin arbiter grants one request at a time. The granted operands are registered and the saturated result is returned on a single response channel with backpressure. A saturating overflow-event counter is kept for debug and performance visibility.

Parameters:
NREQ, 2, number of requesters (2..4)
IDW, 2, width of rsp_id (ceil(log2(NREQ)), minimum 1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_a  in  16*NREQ  operand A; slice i belongs to requester i
req_b  in  16*NREQ  operand B; slice i belongs to requester i
req_sub  in  NREQ  1 = A-B, 0 = A+B
req_ready  out  NREQ  one-hot accept strobe to the granted requester
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_id  out  IDW  index of the requester that owns the result
rsp_sum  out  16  saturated result
rsp_ovfl  out  1  signed overflow occurred (result was saturated)
ovfl_cnt  out  16  count of overflowed operations, saturates at 0xFFFF
ovfl_cnt_clr  in  1  synchronous clear of ovfl_cnt

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_sum=0; rsp_ovfl=0; ovfl_cnt=0; last-grant pointer=NREQ-1, so requester 0 has top priority after reset.
- FSM states: IDLE, EXEC, HOLD.
- IDLE:
  - req_ready is combinational and one-hot: it goes to the first requester with req_valid=1, searching from pointer+1 upward and wrapping modulo NREQ.
  - If any req_valid is high, the grant and the accept happen in the same cycle. At the edge the block latches a, b, sub and id, updates the pointer to the granted index, and moves to EXEC.
  - If no req_valid is high, req_ready=0 and the block stays in IDLE.
- EXEC (exactly 1 cycle):
  - Datapath computes A + (sub ? ~B : B) + sub.
  - Signed overflow is detected on the final sign: both effective operands have the same sign and the raw sign differs from it.
  - On overflow: rsp_sum=0x7FFF if the raw sign is 1 (positive overflow), 0x8000 if the raw sign is 0 (negative overflow). Otherwise rsp_sum = raw sum.
  - At the edge: register rsp_sum, rsp_ovfl and rsp_id; set rsp_valid=1; move to HOLD. ovfl_cnt increments on this edge if overflow occurred.
- HOLD:
  - rsp_* outputs are stable while rsp_valid=1 and rsp_ready=0.
  - When rsp_ready=1: rsp_valid falls at the edge and state returns to IDLE.
- Latency: accept edge k, rsp_valid high after edge k+1. Minimum issue interval is 3 cycles (no bypass from HOLD to accept).
- req_ready is 0 in EXEC and HOLD. Requesters hold req_valid and operands until they see req_ready; requests not accepted are not lost.
- ovfl_cnt:
  - Increments by 1 per overflowed operation and stops at 0xFFFF.
  - ovfl_cnt_clr has priority: clear in the same cycle as an increment gives 0.
- Reset mid-operation aborts the operation. No response is produced and the pointer returns to NREQ-1.
- Operand or req_valid changes during EXEC/HOLD have no effect on the in-flight result.

Decomposition:
- Shared package: state encoding (IDLE/EXEC/HOLD), SAT_POS=16'h7FFF, SAT_NEG=16'h8000, operand width constant 16.
- Sub-module sat_addsub16: purely combinational saturating add/sub with ports a, b, sub, sum, ovfl. The arbiter, FSM, registers and counter stay in addsub_arbiter.

Test Plan:
- Reset, then requester 0 with a=0x0005, b=0x0003, sub=0 -> req_ready=01 for one cycle; two cycles later rsp_valid=1, rsp_sum=0x0008, rsp_ovfl=0, rsp_id=0.
- Saturation: 0x7FFF+0x0001 -> rsp_sum=0x7FFF, ovfl=1. 0x8000-0x0001 -> 0x8000, ovfl=1. 0x8000-0x8000 -> 0x0000, ovfl=0. ovfl_cnt=2 after the three operations.
- Round robin: both req_valid held high for 4 operations with rsp_ready=1 -> grant order 0,1,0,1; rsp_id sequence matches.
- Backpressure: rsp_ready=0 for 5 cycles with a pending request from requester 1 -> rsp_* stable, req_ready stays 0; a rsp_ready pulse releases HOLD, and requester 1 is accepted in the following IDLE cycle.
- Counter: drive 0xFFFF overflow events (force/preload) -> ovfl_cnt stays 0xFFFF. ovfl_cnt_clr asserted on the same edge as an overflow -> ovfl_cnt=0.
- Reset mid-operation: assert rst_n=0 while in EXEC -> outputs go to reset values immediately, no rsp_valid after release, and requester 0 wins the next simultaneous request.
